kmkz_ahb_ifetch: RTL

- Instruction-fetch bus master between the Kamikaze-uRV fetch stage and the AHB-Lite instruction port (HADDR_I … HRESP_I).
- Turns word fetch requests into pipelined SINGLE/NONSEQ reads, with back-to-back issue at one fetch per cycle.
- Absorbs slave wait states and returns read data, or an error flag, to the core in request order.
- Supports flush on redirect: in-flight fetches still complete on the bus, but their results are discarded.

---
 rtl/kmkz_ahb_ifetch_if.sv | 43 ++++
 rtl/kmkz_ahb_ifetch.sv | 134 +++++++++++++
 2 files changed

// File: rtl/kmkz_ahb_ifetch_if.sv
// Fetch-port bundle for kmkz_ahb_ifetch: core-side request/response handshake
// plus the AHB-Lite instruction-port master and slave signals.
//   master : the fetch unit (drives the AHB master outputs and the core responses)
//   slave  : the environment (the core request side and the AHB slave response)
interface kmkz_ahb_ifetch_if;
    // core request / response
    logic [31:0] im_addr_i;
    logic        im_req_i;
    logic        im_ready_o;
    logic        flush_i;
    logic [31:0] im_data_o;
    logic        im_valid_o;
    logic        im_err_o;
    // AHB-Lite master outputs
    logic [31:0] HADDR_I;
    logic [1:0]  HTRANS_I;
    logic [2:0]  HSIZE_I;
    logic [2:0]  HBURST_I;
    logic [3:0]  HPROT_I;
    logic        HMASTLOCK_I;
    logic        HWRITE_I;
    logic [31:0] HWDATA_I;
    // AHB-Lite slave response
    logic [31:0] HRDATA_I;
    logic        HREADY_I;
    logic        HRESP_I;

    modport master (
        input  im_addr_i, im_req_i, flush_i,
        output im_ready_o, im_data_o, im_valid_o, im_err_o,
        output HADDR_I, HTRANS_I, HSIZE_I, HBURST_I, HPROT_I,
        output HMASTLOCK_I, HWRITE_I, HWDATA_I,
        input  HRDATA_I, HREADY_I, HRESP_I
    );

    modport slave (
        output im_addr_i, im_req_i, flush_i,
        input  im_ready_o, im_data_o, im_valid_o, im_err_o,
        input  HADDR_I, HTRANS_I, HSIZE_I, HBURST_I, HPROT_I,
        input  HMASTLOCK_I, HWRITE_I, HWDATA_I,
        output HRDATA_I, HREADY_I, HRESP_I
    );
endinterface

// File: rtl/kmkz_ahb_ifetch.sv
// Instruction-fetch AHB-Lite master. Turns core word-fetch requests into
// pipelined SINGLE/NONSEQ reads (one per cycle), absorbs wait states, and
// returns data or an error pulse to the core in request order. A flush lets
// in-flight transfers finish on the bus but drops their results.
// Ports:
//   CLK  : system/AHB clock
//   RST  : asynchronous active-high reset
//   bus  : kmkz_ahb_ifetch_if.master (core handshake + AHB-Lite master port)
module kmkz_ahb_ifetch #(
    parameter logic [3:0] HPROT_FETCH = 4'b0010
) (
    input  logic                      CLK,
    input  logic                      RST,
    kmkz_ahb_ifetch_if.master         bus
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    localparam logic [1:0]    HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]    HTRANS_NONSEQ = 2'b10;
    localparam logic [AW-1:0] WORD_MASK     = ~AW'(3);

    // address phase
    logic          ap_valid_q, ap_valid_d;
    logic [AW-1:0] ap_addr_q,  ap_addr_d;
    logic          ap_kill_q,  ap_kill_d;
    // data phase
    logic          dp_valid_q, dp_valid_d;
    logic          dp_kill_q,  dp_kill_d;
    // core response
    logic          im_valid_q, im_valid_d;
    logic          im_err_q,   im_err_d;
    logic [DW-1:0] im_data_q,  im_data_d;

    logic err1_c;
    logic ap_adv_c;
    logic ready_c;
    logic accept_c;
    logic drop_c;

    // Handshake and error-detection terms
    always_comb begin
        err1_c   = dp_valid_q & bus.HRESP_I & ~bus.HREADY_I;
        ap_adv_c = bus.HREADY_I | ~ap_valid_q;
        ready_c  = ap_adv_c & ~err1_c;
        accept_c = bus.im_req_i & ready_c;
        // a result completing now is dropped if its fetch was killed or a flush arrives with it
        drop_c   = dp_kill_q | bus.flush_i;
    end

    // Next-state logic for both pipeline stages and the core response
    always_comb begin
        ap_valid_d = ap_valid_q;
        ap_addr_d  = ap_addr_q;
        ap_kill_d  = ap_kill_q;
        dp_valid_d = dp_valid_q;
        dp_kill_d  = dp_kill_q;
        im_valid_d = 1'b0;
        im_err_d   = 1'b0;
        im_data_d  = im_data_q;

        if (err1_c) begin
            // first error cycle: withdraw the pending address phase so the
            // second error cycle shows IDLE
            ap_valid_d = 1'b0;
            ap_kill_d  = 1'b0;
        end else if (ap_adv_c) begin
            // a request taken together with flush is the redirect target: not killed
            ap_valid_d = accept_c;
            ap_addr_d  = bus.im_addr_i & WORD_MASK;
            ap_kill_d  = 1'b0;
        end else begin
            // held address phase is still issued, only its result is dropped
            ap_kill_d  = ap_kill_q | bus.flush_i;
        end

        if (bus.HREADY_I) begin
            dp_valid_d = ap_valid_q;
            dp_kill_d  = ap_kill_q | bus.flush_i;
        end else if (dp_valid_q) begin
            dp_kill_d  = dp_kill_q | bus.flush_i;
        end

        if (dp_valid_q && bus.HREADY_I) begin
            if (bus.HRESP_I) begin
                im_err_d   = ~drop_c;
            end else begin
                im_valid_d = ~drop_c;
                im_data_d  = bus.HRDATA_I;
            end
        end
    end

    // State registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ap_valid_q <= 1'b0;
            ap_addr_q  <= '0;
            ap_kill_q  <= 1'b0;
            dp_valid_q <= 1'b0;
            dp_kill_q  <= 1'b0;
            im_valid_q <= 1'b0;
            im_err_q   <= 1'b0;
            im_data_q  <= '0;
        end else begin
            ap_valid_q <= ap_valid_d;
            ap_addr_q  <= ap_addr_d;
            ap_kill_q  <= ap_kill_d;
            dp_valid_q <= dp_valid_d;
            dp_kill_q  <= dp_kill_d;
            im_valid_q <= im_valid_d;
            im_err_q   <= im_err_d;
            im_data_q  <= im_data_d;
        end
    end

    // Core side
    assign bus.im_ready_o  = ready_c;
    assign bus.im_valid_o  = im_valid_q;
    assign bus.im_err_o    = im_err_q;
    assign bus.im_data_o   = im_data_q;

    // AHB master side; address/transfer come straight from the address-phase register
    assign bus.HTRANS_I    = ap_valid_q ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.HADDR_I     = ap_addr_q;
    assign bus.HSIZE_I     = 3'b010;
    assign bus.HBURST_I    = 3'b000;
    assign bus.HPROT_I     = HPROT_FETCH;
    assign bus.HMASTLOCK_I = 1'b0;
    assign bus.HWRITE_I    = 1'b0;
    assign bus.HWDATA_I    = '0;

endmodule
